// File: rtl/exc_flush_ctrl_pkg.sv
// Shared types and field positions for the exception/return flush controller.
// Used by WB, the CSR file and the controller so all agree on encodings.
package exc_flush_ctrl_pkg;

  typedef enum logic {
    EXC_IDLE  = 1'b0,
    EXC_REDIR = 1'b1
  } exc_state_e;

  localparam logic [5:0] ECODE_INT = 6'h00;

  localparam int TCFG_EN         = 0;
  localparam int TCFG_PERIODIC   = 1;
  localparam int TCFG_INITVAL_LO = 2;
  localparam int TCFG_INITVAL_HI = 31;

  // InitVal counts in units of four cycles, hence the two zero LSBs.
  function automatic logic [31:0] tcfg_load(input logic [31:0] wdata);
    return {wdata[TCFG_INITVAL_HI:TCFG_INITVAL_LO], 2'b00};
  endfunction

endpackage

// File: rtl/exc_flush_ctrl_if.sv
// Bundles the WB event, CSR and IF redirect signals seen by exc_flush_ctrl.
// master = pipeline/CSR side driving events, slave = the controller.
interface exc_flush_ctrl_if #(
  parameter int PC_W = 32
);
  logic            wb_valid;
  logic            wb_ex;
  logic [PC_W-1:0] wb_pc;
  logic [5:0]      wb_ecode;
  logic [8:0]      wb_esubcode;
  logic            ertn_flush;
  logic [PC_W-1:0] csr_eentry;
  logic [PC_W-1:0] csr_era;
  logic            csr_ie;
  logic            csr_tcfg_we;
  logic [31:0]     csr_tcfg_wdata;
  logic            csr_ticlr;
  logic            redirect_ready;
  logic            flush;
  logic            redirect_valid;
  logic [PC_W-1:0] redirect_pc;
  logic            ex_commit;
  logic [PC_W-1:0] ex_era;
  logic [5:0]      ex_ecode;
  logic [8:0]      ex_esubcode;
  logic            timer_int;
  logic            int_pending;

  modport master (
    output wb_valid, wb_ex, wb_pc, wb_ecode, wb_esubcode, ertn_flush,
           csr_eentry, csr_era, csr_ie, csr_tcfg_we, csr_tcfg_wdata,
           csr_ticlr, redirect_ready,
    input  flush, redirect_valid, redirect_pc, ex_commit, ex_era,
           ex_ecode, ex_esubcode, timer_int, int_pending
  );

  modport slave (
    input  wb_valid, wb_ex, wb_pc, wb_ecode, wb_esubcode, ertn_flush,
           csr_eentry, csr_era, csr_ie, csr_tcfg_we, csr_tcfg_wdata,
           csr_ticlr, redirect_ready,
    output flush, redirect_valid, redirect_pc, ex_commit, ex_era,
           ex_ecode, ex_esubcode, timer_int, int_pending
  );

endinterface

// File: rtl/exc_flush_ctrl_const_timer.sv
// Constant timer: countdown loaded from TCFG, raises the TI flag on expiry.
// Only instantiated when EXC_FLUSH_CTRL_TIMER_EN is defined.
module exc_flush_ctrl_const_timer
  import exc_flush_ctrl_pkg::*;
#(
  parameter int TIMER_W = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tcfg_we_i,
  input  logic [31:0] tcfg_wdata_i,
  input  logic        ticlr_i,
  output logic        timer_int_o
);

  logic [TIMER_W-1:0] cnt_q, cnt_d;
  logic [TIMER_W-1:0] reload_q, reload_d;
  logic               en_q, en_d;
  logic               per_q, per_d;
  logic               ti_q, ti_d;
  logic               expire;

  // A TCFG write overrides the countdown, but an expiry in the same cycle still sets TI.
  always_comb begin
    expire   = en_q && (cnt_q == TIMER_W'(1));
    cnt_d    = cnt_q;
    reload_d = reload_q;
    en_d     = en_q;
    per_d    = per_q;
    if (expire) begin
      if (per_q) begin
        cnt_d = reload_q;
      end else begin
        cnt_d = '0;
        en_d  = 1'b0;
      end
    end else if (en_q && (cnt_q != '0)) begin
      cnt_d = cnt_q - TIMER_W'(1);
    end
    if (tcfg_we_i) begin
      cnt_d    = TIMER_W'(tcfg_load(tcfg_wdata_i));
      reload_d = TIMER_W'(tcfg_load(tcfg_wdata_i));
      en_d     = tcfg_wdata_i[TCFG_EN];
      per_d    = tcfg_wdata_i[TCFG_PERIODIC];
    end
    ti_d = ti_q;
    if (ticlr_i) ti_d = 1'b0;
    if (expire)  ti_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q    <= '0;
      reload_q <= '0;
      en_q     <= 1'b0;
      per_q    <= 1'b0;
      ti_q     <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      reload_q <= reload_d;
      en_q     <= en_d;
      per_q    <= per_d;
      ti_q     <= ti_d;
    end
  end

  assign timer_int_o = ti_q;

endmodule

// File: rtl/exc_flush_ctrl.sv
// Exception/ertn flush sequencer: flush + CSR commit, then a held IF redirect.
// Timer interrupt support is built only with EXC_FLUSH_CTRL_TIMER_EN defined.
module exc_flush_ctrl
  import exc_flush_ctrl_pkg::*;
#(
  parameter int TIMER_W = 32,
  parameter int PC_W    = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  exc_flush_ctrl_if.slave      bus
);

  exc_state_e      state_q, state_d;
  logic [PC_W-1:0] redir_pc_q, redir_pc_d;
  logic            ev_ex, ev_ret;
  logic            flush, ex_commit;

  assign ev_ex  = bus.wb_valid & bus.wb_ex;
  assign ev_ret = bus.wb_valid & bus.ertn_flush & ~bus.wb_ex;

  // WB events are only accepted in IDLE; in REDIR flush keeps stale stages dead.
  always_comb begin
    state_d    = state_q;
    redir_pc_d = redir_pc_q;
    flush      = 1'b0;
    ex_commit  = 1'b0;
    case (state_q)
      EXC_IDLE: begin
        if (ev_ex) begin
          flush      = 1'b1;
          ex_commit  = 1'b1;
          redir_pc_d = bus.csr_eentry;
          state_d    = EXC_REDIR;
        end else if (ev_ret) begin
          flush      = 1'b1;
          redir_pc_d = bus.csr_era;
          state_d    = EXC_REDIR;
        end
      end
      EXC_REDIR: begin
        flush = 1'b1;
        if (bus.redirect_ready) state_d = EXC_IDLE;
      end
      default: state_d = EXC_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= EXC_IDLE;
      redir_pc_q <= '0;
    end else begin
      state_q    <= state_d;
      redir_pc_q <= redir_pc_d;
    end
  end

  assign bus.flush          = flush;
  assign bus.ex_commit      = ex_commit;
  assign bus.redirect_valid = (state_q == EXC_REDIR);
  assign bus.redirect_pc    = redir_pc_q;
  assign bus.ex_era         = ex_commit ? bus.wb_pc       : '0;
  assign bus.ex_ecode       = ex_commit ? bus.wb_ecode    : '0;
  assign bus.ex_esubcode    = ex_commit ? bus.wb_esubcode : '0;

`ifdef EXC_FLUSH_CTRL_TIMER_EN
  logic timer_int;

  exc_flush_ctrl_const_timer #(
    .TIMER_W (TIMER_W)
  ) u_const_timer (
    .clk          (clk),
    .reset        (reset),
    .tcfg_we_i    (bus.csr_tcfg_we),
    .tcfg_wdata_i (bus.csr_tcfg_wdata),
    .ticlr_i      (bus.csr_ticlr),
    .timer_int_o  (timer_int)
  );

  assign bus.timer_int   = timer_int;
  assign bus.int_pending = timer_int & bus.csr_ie & (state_q == EXC_IDLE);
`else
  logic unused_timer;
  assign unused_timer    = ^{bus.csr_tcfg_we, bus.csr_tcfg_wdata, bus.csr_ticlr, bus.csr_ie};
  assign bus.timer_int   = 1'b0;
  assign bus.int_pending = 1'b0;
`endif

endmodule

// File: tb/tb_exc_flush_ctrl.sv
// Self-checking bench for exc_flush_ctrl: vector table through a scoreboard,
// plus hand sequences for reset-in-REDIR and the timer (EXC_FLUSH_CTRL_TIMER_EN).
module tb_exc_flush_ctrl;

  typedef struct {
    logic        wbValid, wbEx, ertn;
    logic [31:0] wbPc;
    logic [5:0]  ecode;
    logic [8:0]  esub;
    logic [31:0] eentry, era;
    logic        ready;
    logic        expFlush, expRv;
    logic [31:0] expRpc;
    logic        expCommit;
    logic [31:0] expEra;
    logic [5:0]  expEcode;
    logic [8:0]  expEsub;
  } vec_t;

  typedef struct {
    int          idx;
    logic        flush, rv;
    logic [31:0] rpc;
    logic        commit;
    logic [31:0] era;
    logic [5:0]  ecode;
    logic [8:0]  esub;
  } exp_t;

  logic clk;
  logic reset;
  int   compared;
  int   mismatched;
  exp_t scoreboard[$];
  vec_t vecs[15];

  exc_flush_ctrl_if #(.PC_W(32)) bus ();

  exc_flush_ctrl #(
    .TIMER_W (32),
    .PC_W    (32)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mkVec(
    input logic v, ex, rt, input logic [31:0] pc, input logic [5:0] ec,
    input logic [8:0] es, input logic [31:0] ee, er, input logic rdy,
    input logic eF, eRv, input logic [31:0] eRpc, input logic eC,
    input logic [31:0] eEra, input logic [5:0] eEc, input logic [8:0] eEs);
    vec_t r;
    r.wbValid = v;   r.wbEx = ex;   r.ertn = rt;   r.wbPc = pc;
    r.ecode = ec;    r.esub = es;   r.eentry = ee; r.era = er;
    r.ready = rdy;   r.expFlush = eF; r.expRv = eRv; r.expRpc = eRpc;
    r.expCommit = eC; r.expEra = eEra; r.expEcode = eEc; r.expEsub = eEs;
    return r;
  endfunction

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic quietInputs();
    bus.wb_valid = 1'b0;       bus.wb_ex = 1'b0;       bus.ertn_flush = 1'b0;
    bus.wb_pc = '0;            bus.wb_ecode = '0;      bus.wb_esubcode = '0;
    bus.csr_eentry = '0;       bus.csr_era = '0;       bus.redirect_ready = 1'b0;
    bus.csr_tcfg_we = 1'b0;    bus.csr_tcfg_wdata = '0; bus.csr_ticlr = 1'b0;
  endtask

  task automatic applyStimulus(input int idx, input vec_t v);
    exp_t e;
    @(negedge clk);
    bus.wb_valid = v.wbValid; bus.wb_ex = v.wbEx;       bus.ertn_flush = v.ertn;
    bus.wb_pc = v.wbPc;       bus.wb_ecode = v.ecode;   bus.wb_esubcode = v.esub;
    bus.csr_eentry = v.eentry; bus.csr_era = v.era;     bus.redirect_ready = v.ready;
    e.idx = idx;      e.flush = v.expFlush; e.rv = v.expRv; e.rpc = v.expRpc;
    e.commit = v.expCommit; e.era = v.expEra; e.ecode = v.expEcode; e.esub = v.expEsub;
    scoreboard.push_back(e);
  endtask

  task automatic checkOutput();
    exp_t e;
    #2;
    if (scoreboard.size() == 0) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL scoreboard: empty queue, got 0 entries, expected 1");
      return;
    end
    e = scoreboard.pop_front();
    checkVal($sformatf("vec%0d flush", e.idx), 32'(bus.flush), 32'(e.flush));
    checkVal($sformatf("vec%0d redirect_valid", e.idx), 32'(bus.redirect_valid), 32'(e.rv));
    checkVal($sformatf("vec%0d ex_commit", e.idx), 32'(bus.ex_commit), 32'(e.commit));
    if (e.rv) checkVal($sformatf("vec%0d redirect_pc", e.idx), bus.redirect_pc, e.rpc);
    if (e.commit) begin
      checkVal($sformatf("vec%0d ex_era", e.idx), bus.ex_era, e.era);
      checkVal($sformatf("vec%0d ex_ecode", e.idx), 32'(bus.ex_ecode), 32'(e.ecode));
      checkVal($sformatf("vec%0d ex_esubcode", e.idx), 32'(bus.ex_esubcode), 32'(e.esub));
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkVal({tag, " flush"}, 32'(bus.flush), 32'd0);
    checkVal({tag, " redirect_valid"}, 32'(bus.redirect_valid), 32'd0);
    checkVal({tag, " redirect_pc"}, bus.redirect_pc, 32'd0);
    checkVal({tag, " ex_commit"}, 32'(bus.ex_commit), 32'd0);
    checkVal({tag, " ex_era"}, bus.ex_era, 32'd0);
    checkVal({tag, " ex_ecode"}, 32'(bus.ex_ecode), 32'd0);
    checkVal({tag, " ex_esubcode"}, 32'(bus.ex_esubcode), 32'd0);
    checkVal({tag, " timer_int"}, 32'(bus.timer_int), 32'd0);
    checkVal({tag, " int_pending"}, 32'(bus.int_pending), 32'd0);
  endtask

  task automatic tcfgWrite(input logic [31:0] data);
    @(negedge clk);
    bus.csr_tcfg_we = 1'b1;
    bus.csr_tcfg_wdata = data;
    @(posedge clk);
    @(negedge clk);
    bus.csr_tcfg_we = 1'b0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic ti;
    compared = 0;
    mismatched = 0;
    bus.csr_ie = 1'b1;
    quietInputs();

    // rows: inputs {v,ex,ertn,pc,ecode,esub,eentry,era,ready} -> {flush,rv,rpc,commit,era,ecode,esub}
    vecs[0]  = mkVec(0,0,0,32'h0,6'h00,9'h0,32'h0,32'h0,0,              0,0,32'h0,0,32'h0,6'h00,9'h0);
    vecs[1]  = mkVec(1,1,0,32'h1C000010,6'h0B,9'h1,32'h1C008000,32'h0,0, 1,0,32'h0,1,32'h1C000010,6'h0B,9'h1);
    vecs[2]  = mkVec(0,0,0,32'h0,6'h00,9'h0,32'h0,32'h0,0,              1,1,32'h1C008000,0,32'h0,6'h00,9'h0);
    vecs[3]  = vecs[2];
    vecs[4]  = vecs[2];
    vecs[5]  = mkVec(0,0,0,32'h0,6'h00,9'h0,32'h0,32'h0,1,              1,1,32'h1C008000,0,32'h0,6'h00,9'h0);
    vecs[6]  = mkVec(1,0,1,32'h1C000000,6'h00,9'h0,32'h1C008000,32'h1C000014,1, 1,0,32'h0,0,32'h0,6'h00,9'h0);
    vecs[7]  = mkVec(0,0,0,32'h0,6'h00,9'h0,32'h0,32'h0,1,              1,1,32'h1C000014,0,32'h0,6'h00,9'h0);
    vecs[8]  = mkVec(0,0,0,32'h0,6'h00,9'h0,32'h0,32'h0,0,              0,0,32'h0,0,32'h0,6'h00,9'h0);
    vecs[9]  = mkVec(1,1,1,32'h1C000020,6'h08,9'h2,32'h1C008000,32'h1C000014,0, 1,0,32'h0,1,32'h1C000020,6'h08,9'h2);
    vecs[10] = mkVec(1,1,0,32'h1C000030,6'h0C,9'h3,32'h1C009000,32'h1C000014,0, 1,1,32'h1C008000,0,32'h0,6'h00,9'h0);
    vecs[11] = mkVec(1,0,1,32'h1C000034,6'h00,9'h0,32'h1C009000,32'h1C000050,1, 1,1,32'h1C008000,0,32'h0,6'h00,9'h0);
    vecs[12] = mkVec(0,1,0,32'h1C000038,6'h0B,9'h0,32'h1C009000,32'h1C000050,0, 0,0,32'h0,0,32'h0,6'h00,9'h0);
    vecs[13] = mkVec(1,0,1,32'h1C00003C,6'h00,9'h0,32'h1C009000,32'h1C000040,0, 1,0,32'h0,0,32'h0,6'h00,9'h0);
    vecs[14] = mkVec(0,0,0,32'h0,6'h00,9'h0,32'h0,32'h0,0,              1,1,32'h1C000040,0,32'h0,6'h00,9'h0);

    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkAllZero("reset");
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 15; i++) begin
      applyStimulus(i, vecs[i]);
      checkOutput();
    end

    // Still in REDIR from the last row: reset must drop the redirect with no handshake.
    @(negedge clk);
    quietInputs();
    #1;
    checkVal("preReset redirect_valid", 32'(bus.redirect_valid), 32'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    checkAllZero("resetInRedir");
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    checkVal("postReset redirect_valid", 32'(bus.redirect_valid), 32'd0);

`ifdef EXC_FLUSH_CTRL_TIMER_EN
    // One-shot, InitVal=2: TI rises on the 8th edge after the write and stays set.
    bus.csr_ie = 1'b1;
    @(negedge clk);
    bus.csr_tcfg_we = 1'b1;
    bus.csr_tcfg_wdata = 32'h0000_0009;
    @(posedge clk);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      bus.csr_tcfg_we = 1'b0;
      @(posedge clk);
      #1;
      checkVal($sformatf("oneShot k%0d timer_int", k), 32'(bus.timer_int), 32'(k >= 8));
      checkVal($sformatf("oneShot k%0d int_pending", k), 32'(bus.int_pending), 32'(k >= 8));
    end
    @(negedge clk);
    bus.csr_ticlr = 1'b1;
    @(posedge clk);
    #1;
    checkVal("ticlr timer_int", 32'(bus.timer_int), 32'd0);
    @(negedge clk);
    bus.csr_ticlr = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      #1;
      checkVal($sformatf("noRefire k%0d timer_int", k), 32'(bus.timer_int), 32'd0);
    end

    // Periodic, InitVal=1: fires every 4 edges; clears collide with expiry at 4 and 8.
    bus.csr_ie = 1'b0;
    @(negedge clk);
    bus.csr_tcfg_we = 1'b1;
    bus.csr_tcfg_wdata = 32'h0000_0007;
    @(posedge clk);
    ti = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      bus.csr_tcfg_we = 1'b0;
      bus.csr_ticlr = (k == 4) || (k == 6) || (k == 8);
      @(posedge clk);
      #1;
      if (k % 4 == 0) ti = 1'b1;
      else if (bus.csr_ticlr) ti = 1'b0;
      checkVal($sformatf("periodic k%0d timer_int", k), 32'(bus.timer_int), 32'(ti));
      checkVal($sformatf("periodic k%0d int_pending", k), 32'(bus.int_pending), 32'd0);
    end
    @(negedge clk);
    bus.csr_ticlr = 1'b0;
    tcfgWrite(32'h0);
    bus.csr_ie = 1'b1;
    #1;
    checkVal("ieOn int_pending", 32'(bus.int_pending), 32'd1);

    // int_pending is masked while a redirect is outstanding.
    bus.wb_valid = 1'b1;
    bus.wb_ex = 1'b1;
    bus.csr_eentry = 32'h1C008000;
    @(posedge clk);
    @(negedge clk);
    quietInputs();
    #1;
    checkVal("redir int_pending", 32'(bus.int_pending), 32'd0);
    checkVal("redir timer_int", 32'(bus.timer_int), 32'd1);
    bus.redirect_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.redirect_ready = 1'b0;
    #1;
    checkVal("backIdle int_pending", 32'(bus.int_pending), 32'd1);
`else
    tcfgWrite(32'h0000_0007);
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      checkVal($sformatf("noTimer k%0d timer_int", k), 32'(bus.timer_int), 32'd0);
      checkVal($sformatf("noTimer k%0d int_pending", k), 32'(bus.int_pending), 32'd0);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/exc_flush_ctrl.md
Name: exc_flush_ctrl

Overview:
- Exception/return sequencing controller between the WB stage, the CSR file and IF.
- Turns WB-stage exception (wb_ex) and return (ertn_flush) events into a pipeline flush, a CSR commit pulse and a redirect handshake toward IF.
- Owns the constant timer and raises the timer-interrupt pending flag that ID uses to tag the next instruction.

Parameters:
- TIMER_W, 32, width of timer countdown register.
- PC_W, 32, width of PC/redirect addresses.

Ports:
- clk  in  1  clock
- reset  in  1  reset
- wb_valid  in  1  WB holds a valid instruction
- wb_ex  in  1  WB instruction raises exception
- wb_pc  in  PC_W  PC of WB instruction
- wb_ecode  in  6  exception code
- wb_esubcode  in  9  exception subcode
- ertn_flush  in  1  WB instruction is ertn
- csr_eentry  in  PC_W  exception entry address
- csr_era  in  PC_W  return address
- csr_ie  in  1  CRMD.IE global interrupt enable
- csr_tcfg_we  in  1  TCFG write strobe
- csr_tcfg_wdata  in  32  [0]=En, [1]=Periodic, [31:2]=InitVal
- csr_ticlr  in  1  clear timer-interrupt flag
- redirect_ready  in  1  IF accepts redirect
- flush  out  1  cancel all younger pipeline stages
- redirect_valid  out  1  redirect request to IF
- redirect_pc  out  PC_W  redirect target
- ex_commit  out  1  one-cycle pulse: CSR saves ERA/ESTAT
- ex_era  out  PC_W  PC to save in ERA
- ex_ecode  out  6  ecode to save
- ex_esubcode  out  9  esubcode to save
- timer_int  out  1  ESTAT.TI flag
- int_pending  out  1  interrupt to tag on next ID instruction

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset).
- Reset values:
  - All outputs 0.
  - State is IDLE.
  - Timer count is 0 with En=0.
  - redirect_pc is 0.
- Event definitions:
  - ev_ex = wb_valid & wb_ex.
  - ev_ret = wb_valid & ertn_flush & ~wb_ex. Exception has priority over ertn.
- State IDLE:
  - On ev_ex: in the same cycle, combinationally assert flush=1 and ex_commit=1, with ex_era=wb_pc, ex_ecode=wb_ecode, ex_esubcode=wb_esubcode. Register redirect_pc<=csr_eentry and go to REDIR.
  - On ev_ret: flush=1, ex_commit=0; register redirect_pc<=csr_era; go to REDIR.
  - Otherwise flush=0.
- State REDIR:
  - redirect_valid=1 and flush=1 are held, which keeps killing any residual stage contents.
  - redirect_pc is held stable.
  - WB events in this state are ignored: no ex_commit, no target change.
  - When redirect_ready=1, go to IDLE the next cycle. Minimum REDIR occupancy is 1 cycle.
- Event latency: one event gives exactly 1 ex_commit pulse (for exceptions) and exactly 1 accepted redirect.
- Reset mid-REDIR: return to IDLE and drop redirect_valid with no handshake.
- Timer:
  - csr_tcfg_we loads cnt<={InitVal,2'b00} and latches En/Periodic.
  - When En=1 and cnt!=0: cnt decrements by 1 per cycle.
  - When En=1 and cnt==1: the next cycle sets timer_int=1. If Periodic, cnt reloads to {InitVal,2'b00}; otherwise En clears and cnt stays 0.
  - InitVal=0 never fires.
- timer_int:
  - Cleared by csr_ticlr.
  - Set and clear in the same cycle: set wins.
  - tcfg write in the same cycle as expiry: the write wins for cnt; TI is still set.
- int_pending = timer_int & csr_ie & (state==IDLE). It is combinational and carries no handshake.

Optional Feature:
- Macro EXC_FLUSH_CTRL_TIMER_EN.
- Defined: timer logic as above.
- Undefined: timer registers are removed, and timer_int and int_pending are tied to 0. TCFG/TICLR inputs stay as ports and are ignored.

Decomposition:
- macro.vh gains the following so WB and the CSR file share them:
  - ECODE_INT
  - TCFG field positions (TCFG_EN, TCFG_PERIODIC, TCFG_INITVAL range)
  - State encodings EXC_IDLE=1'b0, EXC_REDIR=1'b1
- One natural sub-module is const_timer (countdown plus TI flag), instantiated under the macro.

Test Plan:
- Exception accept: wb_valid=1, wb_ex=1, wb_pc=0x1C000010, ecode=0x0B, csr_eentry=0x1C008000, redirect_ready=0 for 3 cycles -> flush and ex_commit in cycle 0 with ex_era=0x1C000010; redirect_valid=1 and redirect_pc=0x1C008000 held for 3 cycles; back to IDLE after ready.
- Return: ertn_flush=1, csr_era=0x1C000014, redirect_ready=1 -> flush=1, ex_commit=0, one redirect to 0x1C000014, then IDLE.
- Priority/ignore: wb_ex and ertn_flush both 1 -> target eentry. A second wb_ex during REDIR -> no second ex_commit, redirect_pc unchanged.
- One-shot timer: tcfg_wdata={InitVal=2,P=0,En=1} -> timer_int rises 8 cycles after the write, then stays set; ticlr clears it; no refire.
- Periodic with clear collision: InitVal=1, P=1, ticlr asserted in the expiry cycle -> timer_int stays 1; re-fires every 4 cycles. With csr_ie=0, int_pending stays 0.
- Reset in REDIR: reset asserted while redirect_valid=1 -> next cycle all outputs 0, state IDLE.
